// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game types and peer handoff register map
//
// Purpose: types and constants shared by game_controller and the ball handoff
//          sequencer. It holds the ball type encoding, the peer slave register
//          indices, and a helper that packs the ball exit state into the five
//          handoff bytes.
// Ports:   none (package)
package game_pkg;

  typedef enum logic [1:0] {
    PINGPONG = 2'd0,
    SOCCER   = 2'd1,
    BASKET   = 2'd2
  } ball_type_e;

  localparam int NUM_HANDOFF_REGS = 5;

  localparam logic [2:0] REG_Y0        = 3'd0;
  localparam logic [2:0] REG_Y1        = 3'd1;
  localparam logic [2:0] REG_VY        = 3'd2;
  localparam logic [2:0] REG_GPHASE    = 3'd3;
  localparam logic [2:0] REG_BALLSPEED = 3'd4;

  typedef logic [NUM_HANDOFF_REGS-1:0][7:0] handoff_payload_t;

  // The peer register layout has the y MSBs left-justified and the ball type
  // shifted up by one.
  function automatic handoff_payload_t pack_handoff(
    input logic [9:0] y,
    input logic [7:0] vy,
    input logic [1:0] gphase,
    input logic [1:0] btype
  );
    handoff_payload_t p;
    p[REG_Y0]        = {y[9:8], 6'b0};
    p[REG_Y1]        = y[7:0];
    p[REG_VY]        = vy;
    p[REG_GPHASE]    = {6'b0, gphase};
    p[REG_BALLSPEED] = {5'b0, btype, 1'b0};
    return p;
  endfunction

endpackage

// File: rtl/link_timer.sv
// rtl/link_timer.sv - clearable up-counter with terminal-count flag
//
// Purpose: counts enabled cycles since the last clear and flags when the count
//          has reached TERMINAL_COUNT. The count parks at the terminal value.
// Ports:
//   clk_i     in  clock
//   rst_i     in  async active-high reset
//   clear_i   in  synchronous clear (wins over enable)
//   enable_i  in  count enable
//   tc_o      out terminal count reached while enabled and not clearing
module link_timer #(
  parameter int WIDTH          = 25,
  parameter int TERMINAL_COUNT = 24_999_999
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(TERMINAL_COUNT);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && (count_q != LAST)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign tc_o = enable_i & ~clear_i & (count_q == LAST);

endmodule

// File: rtl/ball_handoff_sequencer.sv
// rtl/ball_handoff_sequencer.sv - hands the exiting ball to the peer over I2C
//
// Purpose: on send_trigger, latches the ball exit state, writes it as five
//          bytes to the peer through an I2C byte-write master (with NACK
//          retries), then strobes go_right_out and waits for the peer's
//          busy-accept handshake. A handshake timeout or too many NACKs give
//          a sticky link_error.
// Ports:
//   clk_25MHZ        in  clock
//   reset            in  async active-high reset
//   send_trigger     in  start a handoff (pulse)
//   ball_y/ball_vy/gravity_phase/ball_type  in  ball exit state
//   i2c_wr_req       out byte-write request, with i2c_reg_addr / i2c_wr_data
//   i2c_wr_done      in  byte ACKed
//   i2c_nack         in  byte NACKed
//   peer_responding  in  peer busy-accepting
//   clear_error      in  leave ERROR
//   go_right_out     out start strobe to peer
//   busy             out handoff in progress
//   link_error       out sticky failure flag
//   trigger_dropped  out trigger ignored while not idle (pulse)
module ball_handoff_sequencer
  import game_pkg::*;
#(
  parameter int MAX_RETRY   = 3,
  parameter int ACK_TIMEOUT = 25_000_000
) (
  input  logic       clk_25MHZ,
  input  logic       reset,
  input  logic       send_trigger,
  input  logic [9:0] ball_y,
  input  logic [7:0] ball_vy,
  input  logic [1:0] gravity_phase,
  input  logic [1:0] ball_type,
  output logic       i2c_wr_req,
  output logic [2:0] i2c_reg_addr,
  output logic [7:0] i2c_wr_data,
  input  logic       i2c_wr_done,
  input  logic       i2c_nack,
  input  logic       peer_responding,
  input  logic       clear_error,
  output logic       go_right_out,
  output logic       busy,
  output logic       link_error,
  output logic       trigger_dropped
);

  typedef enum logic [2:0] {
    IDLE, LATCH, WRITE, WAIT_DONE, GO_HIGH, GO_LOW, ERROR
  } state_e;

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
  localparam logic [2:0]    LAST_REG    = 3'(NUM_HANDOFF_REGS - 1);

  state_e           state_q;
  handoff_payload_t payload_q;
  handoff_payload_t payload_in;
  logic [2:0]       idx_q;
  logic [RW-1:0]    retry_q;
  logic             wr_req_q;
  logic [2:0]       addr_q;
  logic [7:0]       data_q;
  logic             go_q;
  logic             busy_q;
  logic             link_error_q;
  logic             dropped_q;
  logic             timer_en;
  logic             timer_clr;
  logic             timer_tc;

  assign payload_in = pack_handoff(ball_y, ball_vy, gravity_phase, ball_type);

  // The timer runs only in the two peer-handshake states and restarts on the
  // GO_HIGH -> GO_LOW step, so each state gets a full timeout window.
  assign timer_en  = (state_q == GO_HIGH) || (state_q == GO_LOW);
  assign timer_clr = !timer_en || ((state_q == GO_HIGH) && peer_responding);

  link_timer #(
    .WIDTH          (TW),
    .TERMINAL_COUNT (ACK_TIMEOUT - 1)
  ) u_link_timer (
    .clk_i    (clk_25MHZ),
    .rst_i    (reset),
    .clear_i  (timer_clr),
    .enable_i (timer_en),
    .tc_o     (timer_tc)
  );

  always_ff @(posedge clk_25MHZ or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      payload_q    <= '0;
      idx_q        <= '0;
      retry_q      <= '0;
      wr_req_q     <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      go_q         <= 1'b0;
      busy_q       <= 1'b0;
      link_error_q <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      dropped_q <= send_trigger && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (send_trigger) begin
            state_q <= LATCH;
            busy_q  <= 1'b1;
          end
        end
        LATCH: begin
          // Request byte 0 straight from the capture so it is visible in the
          // first WRITE cycle.
          payload_q <= payload_in;
          idx_q     <= '0;
          retry_q   <= '0;
          wr_req_q  <= 1'b1;
          addr_q    <= REG_Y0;
          data_q    <= payload_in[REG_Y0];
          state_q   <= WRITE;
        end
        WRITE, WAIT_DONE: begin
          // A response only counts while the request is up; WRITE with the
          // request low is the mandatory gap cycle between byte attempts.
          if (wr_req_q && i2c_nack) begin
            wr_req_q <= 1'b0;
            if (retry_q == RETRY_LIMIT) begin
              state_q      <= ERROR;
              link_error_q <= 1'b1;
              busy_q       <= 1'b0;
            end else begin
              retry_q <= retry_q + 1'b1;
              state_q <= WRITE;
            end
          end else if (wr_req_q && i2c_wr_done) begin
            wr_req_q <= 1'b0;
            if (idx_q == LAST_REG) begin
              state_q <= GO_HIGH;
              go_q    <= 1'b1;
            end else begin
              idx_q   <= idx_q + 3'd1;
              state_q <= WRITE;
            end
          end else begin
            wr_req_q <= 1'b1;
            addr_q   <= idx_q;
            data_q   <= payload_q[idx_q];
            state_q  <= WAIT_DONE;
          end
        end
        GO_HIGH: begin
          if (peer_responding) begin
            go_q    <= 1'b0;
            state_q <= GO_LOW;
          end else if (timer_tc) begin
            go_q         <= 1'b0;
            state_q      <= ERROR;
            link_error_q <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
        GO_LOW: begin
          if (!peer_responding) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (timer_tc) begin
            state_q      <= ERROR;
            link_error_q <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
        ERROR: begin
          if (clear_error) begin
            state_q      <= IDLE;
            link_error_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i2c_wr_req      = wr_req_q;
  assign i2c_reg_addr    = addr_q;
  assign i2c_wr_data     = data_q;
  assign go_right_out    = go_q;
  assign busy            = busy_q;
  assign link_error      = link_error_q;
  assign trigger_dropped = dropped_q;

endmodule

// File: tb/tb_ball_handoff_sequencer.sv
// tb/tb_ball_handoff_sequencer.sv - randomized self-checking bench for ball_handoff_sequencer
module tb_ball_handoff_sequencer;

  localparam int MAX_RETRY   = 3;
  localparam int ACK_TIMEOUT = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send_trigger = 1'b0;
  logic [9:0] ball_y = '0;
  logic [7:0] ball_vy = '0;
  logic [1:0] gravity_phase = '0;
  logic [1:0] ball_type = '0;
  logic       i2c_wr_done = 1'b0;
  logic       i2c_nack = 1'b0;
  logic       peer_responding = 1'b0;
  logic       clear_error = 1'b0;
  logic       i2c_wr_req;
  logic [2:0] i2c_reg_addr;
  logic [7:0] i2c_wr_data;
  logic       go_right_out;
  logic       busy;
  logic       link_error;
  logic       trigger_dropped;

  ball_handoff_sequencer #(
    .MAX_RETRY   (MAX_RETRY),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk_25MHZ       (clk),
    .reset           (reset),
    .send_trigger    (send_trigger),
    .ball_y          (ball_y),
    .ball_vy         (ball_vy),
    .gravity_phase   (gravity_phase),
    .ball_type       (ball_type),
    .i2c_wr_req      (i2c_wr_req),
    .i2c_reg_addr    (i2c_reg_addr),
    .i2c_wr_data     (i2c_wr_data),
    .i2c_wr_done     (i2c_wr_done),
    .i2c_nack        (i2c_nack),
    .peer_responding (peer_responding),
    .clear_error     (clear_error),
    .go_right_out    (go_right_out),
    .busy            (busy),
    .link_error      (link_error),
    .trigger_dropped (trigger_dropped)
  );

  always #20 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // I2C master model: logs each request on its rising edge, checks addr/data
  // stay put while it is up, and answers after ack_delay cycles.
  logic [10:0] log_q[$];
  int          nack_cnt[5];
  int          att[5];
  int          ack_delay = 4;
  int          stab_err = 0;
  int          drop_cnt = 0;
  bit          in_req = 0;
  int          req_cnt = 0;
  logic [2:0]  cur_addr = '0;
  logic [7:0]  cur_data = '0;

  always @(negedge clk) begin
    i2c_wr_done = 1'b0;
    i2c_nack    = 1'b0;
    if (trigger_dropped) drop_cnt++;
    if (reset || !i2c_wr_req) begin
      in_req = 0;
    end else begin
      if (!in_req) begin
        in_req   = 1;
        req_cnt  = 0;
        cur_addr = i2c_reg_addr;
        cur_data = i2c_wr_data;
        log_q.push_back({cur_addr, cur_data});
      end else if (i2c_reg_addr !== cur_addr || i2c_wr_data !== cur_data) begin
        stab_err++;
      end
      req_cnt++;
      if (req_cnt == ack_delay) begin
        if (cur_addr < 3'd5 && att[cur_addr] < nack_cnt[cur_addr]) begin
          i2c_nack    = 1'b1;
          i2c_wr_done = 1'($urandom % 2);
        end else begin
          i2c_wr_done = 1'b1;
        end
        if (cur_addr < 3'd5) att[cur_addr]++;
      end
    end
  end

  // Reference: the list of (addr,data) writes the peer should see and whether
  // the handoff ends in a link error, from the register map and retry budget.
  logic [10:0] exp_q[$];
  bit          exp_err;

  task automatic build_model(input logic [9:0] y, input logic [7:0] vy,
                             input logic [1:0] gp, input logic [1:0] bt);
    int bytes[5];
    int total;
    total    = 0;
    bytes[0] = (int'(y) / 256) * 64;
    bytes[1] = int'(y) % 256;
    bytes[2] = int'(vy);
    bytes[3] = int'(gp);
    bytes[4] = int'(bt) * 2;
    exp_q.delete();
    exp_err = 0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j <= nack_cnt[i]; j++) begin
        exp_q.push_back({3'(i), 8'(bytes[i])});
        if (j < nack_cnt[i]) begin
          total++;
          if (total > MAX_RETRY) begin
            exp_err = 1;
            return;
          end
        end
      end
    end
  endtask

  task automatic handoff(input logic [9:0] y, input logic [7:0] vy, input logic [1:0] gp,
                         input logic [1:0] bt, input bit peer_on, input string tag);
    bit got_go;
    bit got_err;
    int n;
    int d0;
    build_model(y, vy, gp, bt);
    log_q.delete();
    for (int i = 0; i < 5; i++) att[i] = 0;
    stab_err = 0;
    @(negedge clk);
    ball_y = y; ball_vy = vy; gravity_phase = gp; ball_type = bt;
    send_trigger = 1'b1;
    @(negedge clk);
    send_trigger = 1'b0;
    chk({tag, "_latch_busy"}, 32'(busy), 1);
    chk({tag, "_latch_req"}, 32'(i2c_wr_req), 0);
    @(negedge clk);
    chk({tag, "_lat_req"}, 32'(i2c_wr_req), 1);
    chk({tag, "_lat_addr"}, 32'(i2c_reg_addr), 0);
    ball_y = 10'($urandom); ball_vy = 8'($urandom);
    gravity_phase = 2'($urandom); ball_type = 2'($urandom);
    got_go = 0; got_err = 0;
    for (n = 0; n < 3000 && !got_go && !got_err; n++) begin
      @(negedge clk);
      got_go  = go_right_out;
      got_err = link_error;
    end
    chk({tag, "_finished"}, 32'(got_go | got_err), 1);
    chk({tag, "_err"}, 32'(got_err), 32'(exp_err));
    chk({tag, "_nwrites"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < log_q.size()) chk({tag, "_write"}, 32'(log_q[i]), 32'(exp_q[i]));
    chk({tag, "_stable"}, 32'(stab_err), 0);
    if (got_err) begin
      chk({tag, "_err_go"}, 32'(go_right_out), 0);
      chk({tag, "_err_req"}, 32'(i2c_wr_req), 0);
      chk({tag, "_err_busy"}, 32'(busy), 0);
      d0 = drop_cnt;
      send_trigger = 1'b1;
      @(negedge clk);
      send_trigger = 1'b0;
      @(negedge clk);
      chk({tag, "_err_drop"}, 32'(drop_cnt - d0), 1);
      chk({tag, "_err_sticky"}, 32'(link_error), 1);
      clear_error = 1'b1;
      @(negedge clk);
      clear_error = 1'b0;
      chk({tag, "_cleared"}, 32'(link_error), 0);
      chk({tag, "_idle_busy"}, 32'(busy), 0);
    end else if (got_go) begin
      if (peer_on) begin
        repeat ($urandom_range(1, 8)) @(negedge clk);
        chk({tag, "_go_hold"}, 32'(go_right_out), 1);
        peer_responding = 1'b1;
        @(negedge clk);
        chk({tag, "_go_fall"}, 32'(go_right_out), 0);
        chk({tag, "_golow_busy"}, 32'(busy), 1);
        repeat ($urandom_range(0, 6)) @(negedge clk);
        peer_responding = 1'b0;
        @(negedge clk);
        chk({tag, "_done_busy"}, 32'(busy), 0);
      end else begin
        n = 0;
        while (!link_error && n < 300) begin
          @(negedge clk);
          n++;
        end
        chk({tag, "_tmo_cycles"}, 32'(n), ACK_TIMEOUT);
        chk({tag, "_tmo_go"}, 32'(go_right_out), 0);
        clear_error = 1'b1;
        @(negedge clk);
        clear_error = 1'b0;
        chk({tag, "_tmo_cleared"}, 32'(link_error), 0);
      end
    end
  endtask

  logic [10:0] golden[5];

  initial begin
    int d0;
    int n;
    bit got_go;
    golden[0] = {3'd0, 8'h80}; golden[1] = {3'd1, 8'hC5}; golden[2] = {3'd2, 8'hFD};
    golden[3] = {3'd3, 8'h02}; golden[4] = {3'd4, 8'h02};
    for (int i = 0; i < 5; i++) begin nack_cnt[i] = 0; att[i] = 0; end

    repeat (2) @(negedge clk);
    chk("rst_req", 32'(i2c_wr_req), 0);
    chk("rst_addr", 32'(i2c_reg_addr), 0);
    chk("rst_data", 32'(i2c_wr_data), 0);
    chk("rst_go", 32'(go_right_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(link_error), 0);
    chk("rst_drop", 32'(trigger_dropped), 0);
    reset = 1'b0;
    @(negedge clk);

    ack_delay = 4;
    handoff(10'h2C5, 8'hFD, 2'd2, 2'd1, 1, "basic");
    for (int i = 0; i < 5; i++)
      if (i < log_q.size()) chk("basic_golden", 32'(log_q[i]), 32'(golden[i]));

    nack_cnt[2] = 2;
    handoff(10'h2C5, 8'hFD, 2'd2, 2'd1, 1, "nack2");
    nack_cnt[2] = 0;

    nack_cnt[0] = 4;
    handoff(10'h155, 8'h7F, 2'd1, 2'd2, 1, "nackerr");
    nack_cnt[0] = 0;

    handoff(10'h3FF, 8'h80, 2'd3, 2'd0, 0, "timeout");

    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 5; i++)
        nack_cnt[i] = ($urandom % 4 == 0) ? $urandom_range(1, 2) : 0;
      ack_delay = $urandom_range(1, 5);
      handoff(10'($urandom), 8'($urandom), 2'($urandom), 2'($urandom_range(0, 2)), 1, "rnd");
    end
    for (int i = 0; i < 5; i++) nack_cnt[i] = 0;

    // Second trigger during WAIT_DONE, then reset while in GO_HIGH.
    ack_delay = 4;
    log_q.delete();
    for (int i = 0; i < 5; i++) att[i] = 0;
    d0 = drop_cnt;
    @(negedge clk);
    ball_y = 10'h0AA; ball_vy = 8'h10; gravity_phase = 2'd0; ball_type = 2'd0;
    send_trigger = 1'b1;
    @(negedge clk);
    send_trigger = 1'b0;
    repeat (2) @(negedge clk);
    send_trigger = 1'b1;
    @(negedge clk);
    send_trigger = 1'b0;
    got_go = 0;
    for (n = 0; n < 3000 && !got_go; n++) begin
      @(negedge clk);
      got_go = go_right_out;
    end
    chk("r28_go", 32'(got_go), 1);
    repeat (5) @(negedge clk);
    chk("r28_drops", 32'(drop_cnt - d0), 1);
    chk("r28_nwrites", 32'(log_q.size()), 5);
    #5 reset = 1'b1;
    #1;
    chk("r28_req", 32'(i2c_wr_req), 0);
    chk("r28_addr", 32'(i2c_reg_addr), 0);
    chk("r28_data", 32'(i2c_wr_data), 0);
    chk("r28_go_rst", 32'(go_right_out), 0);
    chk("r28_busy", 32'(busy), 0);
    chk("r28_err", 32'(link_error), 0);
    chk("r28_dropout", 32'(trigger_dropped), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("r28_idle_busy", 32'(busy), 0);

    handoff(10'h123, 8'hFE, 2'd1, 2'd2, 1, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ball_handoff_sequencer.md
BALL_HANDOFF_SEQUENCER -- requirements
Module: ball_handoff_sequencer

Interface
REQ-001 The block SHALL use one clock, clk_25MHZ; reset SHALL be asynchronous and active-high, port reset.
REQ-002 Parameter MAX_RETRY, default 3, SHALL set the NACK retries allowed per handoff.
REQ-003 Parameter ACK_TIMEOUT, default 25_000_000, SHALL set the peer-response wait in cycles (1 s at 25 MHz).
REQ-004 Ports, one per line:
 clk_25MHZ  in  1  clock
 reset  in  1  async active-high reset
 send_trigger  in  1  one-cycle pulse: ball left the screen, hand off to peer
 ball_y  in  10  ball y at exit
 ball_vy  in  8  signed y velocity at exit
 gravity_phase  in  2  gravity sub-counter at exit
 ball_type  in  2  0 pingpong, 1 soccer, 2 basket
 i2c_wr_req  out  1  byte-write request to I2C master
 i2c_reg_addr  out  3  peer slave register index 0..4
 i2c_wr_data  out  8  byte to write
 i2c_wr_done  in  1  master: byte ACKed
 i2c_nack  in  1  master: byte NACKed
 peer_responding  in  1  peer busy-accepting indication
 clear_error  in  1  leave ERROR
 go_right_out  out  1  start strobe to peer
 busy  out  1  handoff in progress
 link_error  out  1  sticky failure flag
 trigger_dropped  out  1  one-cycle pulse: trigger ignored while busy

Function
REQ-005 States SHALL be IDLE, LATCH, WRITE, WAIT_DONE, GO_HIGH, GO_LOW, ERROR.
REQ-006 IDLE: send_trigger SHALL move to LATCH; all other inputs are ignored.
REQ-007 LATCH SHALL capture the five payload bytes in one cycle: reg0={ball_y[9:8],6'b0}, reg1=ball_y[7:0], reg2=ball_vy, reg3={6'b0,gravity_phase}, reg4={5'b0,ball_type,1'b0}; byte index and retry counter SHALL clear.
REQ-008 Latency SHALL be fixed: trigger in cycle 0, LATCH in cycle 1, i2c_wr_req high in cycle 2.
REQ-009 WRITE SHALL drive i2c_reg_addr=index and i2c_wr_data=payload[index], raise i2c_wr_req, and enter WAIT_DONE.
REQ-010 i2c_wr_req, addr and data SHALL be held stable until i2c_wr_done or i2c_nack is sampled high; i2c_wr_req SHALL then be low for at least one cycle.
REQ-011 i2c_wr_done SHALL advance the index; after index 4 the block SHALL go to GO_HIGH, otherwise return to WRITE.
REQ-012 i2c_nack SHALL retry the same byte and increment the retry counter; a NACK arriving with retry count already equal to MAX_RETRY SHALL go to ERROR.
REQ-013 If done and nack are high in the same cycle, nack SHALL win.
REQ-014 GO_HIGH SHALL assert go_right_out and wait for peer_responding=1, then go to GO_LOW.
REQ-015 GO_LOW SHALL deassert go_right_out and wait for peer_responding=0, then return to IDLE.
REQ-016 The timeout counter SHALL clear on entry to GO_HIGH and to GO_LOW; reaching ACK_TIMEOUT-1 in either state SHALL go to ERROR.
REQ-017 ERROR SHALL hold link_error=1 with i2c_wr_req and go_right_out low; clear_error SHALL return to IDLE and clear link_error in the same edge.
REQ-018 busy SHALL be 1 in every state except IDLE and ERROR.
REQ-019 send_trigger outside IDLE SHALL be ignored and SHALL pulse trigger_dropped for one cycle; this includes ERROR.
REQ-020 Payload SHALL be taken only from the LATCH capture; input changes after LATCH SHALL NOT alter the bytes sent.

Reset
REQ-021 On reset the block SHALL enter IDLE with every output 0, payload, index, retry and timeout counters 0, and link_error 0; reset mid-transfer SHALL drop i2c_wr_req immediately.

Structure
REQ-022 Package game_pkg SHALL hold the ball_type enum (PINGPONG, SOCCER, BASKET), register index constants REG_Y0..REG_BALLSPEED (0..4) and NUM_HANDOFF_REGS=5, shared with game_controller.
REQ-023 The timeout counter SHALL be a sub-module named link_timer (clear, enable, terminal-count pulse, parameter width).

Verification
REQ-024 Input ball_y=0x2C5, ball_vy=-3, gravity_phase=2, ball_type=1, then trigger with the master ACKing every byte after 4 cycles -> bytes 0x80,0xC5,0xFD,0x02,0x02 are written to addresses 0..4 in order, then go_right_out rises.
REQ-025 The master NACKs byte 2 twice -> byte 2 is resent twice with identical addr and data, and the sequence then completes normally.
REQ-026 The master NACKs byte 0 four times with MAX_RETRY=3 -> link_error=1 after the 4th NACK, and clear_error returns the block to IDLE.
REQ-027 peer_responding is never asserted, with ACK_TIMEOUT=100 -> ERROR 100 cycles after GO_HIGH entry and go_right_out=0.
REQ-028 A second trigger during WAIT_DONE, followed by reset asserted mid-GO_HIGH -> trigger_dropped pulses once, and all outputs are 0 asynchronously on reset.
